// File: rtl/wb_initiator_pkg.sv
// -----------------------------------------------------------------------------
// wb_initiator_pkg
// Shared definitions for the single-outstanding Wishbone initiator:
//   - FSM state encoding (IDLE / BUS / RESP)
//   - data width and default watchdog length
//   - helper to size the watchdog counter
// Optional feature macro used by the files importing this package:
//   WB_INITIATOR_TIMEOUT_EN
// -----------------------------------------------------------------------------
package wb_initiator_pkg;

  // Wishbone data width (fixed by the bus).
  localparam int unsigned DATA_W = 32;

  // Default Wishbone address width.
  localparam int unsigned AW_DEFAULT = 16;

  // Default watchdog length in cycles of wb_cyc high without ack.
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  // Legal watchdog range.
  localparam int unsigned TIMEOUT_MIN = 1;
  localparam int unsigned TIMEOUT_MAX = 255;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Width of a saturating counter that must be able to hold the value max_val.
  function automatic int unsigned sat_cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage : wb_initiator_pkg

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Watchdog for one Wishbone cycle. Counts the cycles spent in BUS and flags
// the cycle that is the TIMEOUT-th one with wb_cyc high. Only instantiated
// when WB_INITIATOR_TIMEOUT_EN is defined.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   restart the count (asserted on the accept that enters BUS)
//   enable   in   initiator is in BUS this cycle
//   expired  out  this BUS cycle is the TIMEOUT-th one (no ack -> abort)
// -----------------------------------------------------------------------------
module wb_timeout_cnt
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = sat_cnt_width(TIMEOUT);

  // Number of BUS cycles already completed; saturates at TIMEOUT.
  logic [CNT_W-1:0] cnt_q;

  // Saturating counter, cleared on entry to BUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The current BUS cycle is number cnt_q+1; the count reaches TIMEOUT here.
  assign expired = enable && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));

endmodule : wb_timeout_cnt

// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
// Single-outstanding Wishbone initiator. Converts a valid/ready request stream
// into classic Wishbone cycles (wb_cyc doubles as strobe) and returns each
// result on a valid/ready response stream.
// Optional watchdog: define WB_INITIATOR_TIMEOUT_EN to abort cycles that are
// not acknowledged within TIMEOUT cycles (rsp_err=1). Without it the initiator
// waits for ack forever and rsp_err is constant 0.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_we, req_addr, req_wdata    request payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             response payload
//   wb_addr, wb_wdata, wb_we       Wishbone request (registered)
//   wb_cyc                         Wishbone cycle/strobe
//   wb_rdata, wb_ack               Wishbone response
// -----------------------------------------------------------------------------
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned AW      = AW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  // request stream
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // Wishbone initiator port
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_rdata,
  output logic              wb_we,
  output logic              wb_cyc,
  input  logic              wb_ack
);

  // Reject an out-of-range watchdog length at elaboration.
  if ((TIMEOUT < TIMEOUT_MIN) || (TIMEOUT > TIMEOUT_MAX)) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT must be within 1..255");
  end

  state_e state_q;
  state_e state_d;

  logic accept_c;  // request handshake this cycle
  logic done_c;    // ack received in BUS
  logic abort_c;   // watchdog abort in BUS (never with ack)

  assign accept_c = (state_q == ST_IDLE) && req_valid;
  assign done_c   = (state_q == ST_BUS) && wb_ack;

`ifdef WB_INITIATOR_TIMEOUT_EN
  logic expired_c;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept_c),
    .enable  (state_q == ST_BUS),
    .expired (expired_c)
  );

  // An ack in the expiring cycle takes priority over the abort.
  assign abort_c = (state_q == ST_BUS) && !wb_ack && expired_c;
`else
  assign abort_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid)          state_d = ST_BUS;
      ST_BUS:  if (done_c || abort_c)  state_d = ST_RESP;
      ST_RESP: if (rsp_ready)          state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Handshake and cycle outputs decoded from the state register only.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wb_cyc    = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_BUS:  wb_cyc    = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Wishbone request registers: loaded on accept, stable for the whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr  <= '0;
      wb_wdata <= '0;
      wb_we    <= 1'b0;
    end else if (accept_c) begin
      wb_addr  <= req_addr;
      wb_wdata <= req_wdata;
      wb_we    <= req_we;
    end
  end

  // Response data: written only when leaving BUS, so it holds through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (done_c) begin
      rsp_rdata <= wb_we ? '0 : wb_rdata;
    end else if (abort_c) begin
      rsp_rdata <= '0;
    end
  end

`ifdef WB_INITIATOR_TIMEOUT_EN
  // Error flag: set by an abort, cleared by a normal completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (done_c) begin
      rsp_err <= 1'b0;
    end else if (abort_c) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule : wb_initiator

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone initiator that turns a valid/ready request stream into classic Wishbone cycles and returns each result on a valid/ready response stream. It sits between a command source (SPI bridge, sequencer, test stimulus) and the local Wishbone peripherals, which register `wb_ack` for one cycle and drop it once `wb_cyc` falls. An optional watchdog aborts cycles that are never acknowledged.

## Interface
- `AW`, 16: Wishbone address width.
- `TIMEOUT`, 15: cycles with `wb_cyc` high and no ack before abort; valid range 1..255.
- `clk`  in  1  the only clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready` at a rising edge.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  target address.
- `req_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  response present; held until accepted.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  32  read data; 0 for writes and aborts.
- `rsp_err`  out  1  1 = cycle aborted by timeout.
- `wb_addr`  out  AW
- `wb_wdata`  out  32
- `wb_rdata`  in  32
- `wb_we`  out  1
- `wb_cyc`  out  1  also acts as strobe.
- `wb_ack`  in  1

## Operation
- FSM: IDLE -> BUS -> RESP -> IDLE.
- IDLE: `req_ready`=1. On handshake, register `req_addr/we/wdata` onto `wb_addr/wb_we/wb_wdata`, set `wb_cyc`, go to BUS.
- BUS: `wb_cyc`=1, Wishbone outputs stable. On `wb_ack`=1: clear `wb_cyc`; if read, capture `wb_rdata` into `rsp_rdata`, otherwise load 0; `rsp_err`=0; go to RESP.
- RESP: `rsp_valid`=1, `wb_cyc`=0. On `rsp_ready`, clear `rsp_valid` and go to IDLE. Every cycle therefore has at least two cycles with `wb_cyc` low before the next `wb_cyc`. A duplicate ack cannot be mistaken for a new one.
- `wb_ack` is ignored in IDLE and RESP, including a late ack after an abort.
- `rsp_rdata/rsp_err` stay stable while `rsp_valid`=1.
- Reset (async, any state): state IDLE. `wb_cyc`=0, `wb_we`=0, `wb_addr`=0, `wb_wdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `req_ready` is 1 after release. A cycle in flight is dropped with no response.

## Timing
- `req_ready` and `rsp_valid` are decoded from registered state. There is no combinational path from any input to any output.
- Accept at edge E. `wb_cyc` is high from E+1. If the responder acks in cycle E+1+k, `rsp_valid` is high from E+2+k.
- With a responder that acks the cycle after it sees `wb_cyc` (k=1), `rsp_valid` rises at E+3.
- With `rsp_ready` tied high, back-to-back throughput is one transaction per k+3 cycles. For k=1 that is 4 cycles.
- Timeout counter: cleared on entry to BUS and increments each BUS cycle. Width is clog2(TIMEOUT+1); it saturates and never wraps.
- The counter reaching TIMEOUT with no ack in that cycle triggers an abort. Ack in the same cycle the counter reaches TIMEOUT wins: this is a normal completion.

## Configuration
- `WB_INITIATOR_TIMEOUT_EN` defined: watchdog present. On abort, clear `wb_cyc`, set `rsp_rdata`=0 and `rsp_err`=1, then go to RESP. Abort occurs after exactly TIMEOUT cycles of `wb_cyc` high.
- Not defined: no counter logic. BUS waits forever for ack, `rsp_err` is constant 0, and `TIMEOUT` is unused.

## Structure
- Shared package `wb_initiator_pkg`: state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2) and default `TIMEOUT`.
- One sub-module `wb_timeout_cnt`, present only under the macro.
  - Inputs: clear, enable. Output: expired.
  - Parameter: `TIMEOUT`.
  - Same clock/reset.
- The remainder is a single FSM plus a datapath register file in `wb_initiator`.

## Test plan
- Write 0x0000_0ABC to address 0x0001 with a k=1 responder and `rsp_ready`=1: `wb_cyc` high for exactly 2 cycles with `wb_we`=1; `rsp_valid` pulses one cycle at E+3 with `rsp_rdata`=0 and `rsp_err`=0.
- Read address 0x0002; responder returns 0x0000_0123 with ack: `rsp_rdata`=0x0000_0123, `rsp_err`=0.
- Hold `rsp_ready`=0 for 5 cycles after a read: `rsp_valid` and `rsp_rdata` hold, `req_ready`=0, and `wb_cyc` stays 0 until the response is accepted.
- With the macro on and `TIMEOUT`=15, give no ack: `wb_cyc` falls after 15 cycles high, then `rsp_err`=1 and `rsp_rdata`=0. A late ack 1 cycle later produces no second response. Same stimulus without the macro: `wb_cyc` stays high for 100+ cycles.
- Ack exactly on counter = TIMEOUT: normal completion with `rsp_err`=0.
- Assert `rst_n`=0 mid-BUS: `wb_cyc` drops immediately and asynchronously, no `rsp_valid` appears, and a new request after release completes normally.
